alu_status_register: RTL

//  Output stage directly downstream of the ALU flag generator. Captures the ALU result Q,
//  the opcode and the Z/N/V/C flags into a one-entry registered slot with valid/ready handshake.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_status_register_sat_counter.sv | 37 +++
 rtl/alu_status_register.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and flag-vector definitions for the ALU output stage.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_MUL = 4'b0010;

  // Bit positions inside a packed {N,Z,C,V} flag vector.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  typedef logic [3:0] flags_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } slot_state_t;

  function automatic flags_t pack_flags(input logic n, input logic z,
                                        input logic c, input logic v);
    flags_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_status_register_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] val);
    return (val == MAX_VAL) ? val : val + 1'b1;
  endfunction

  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = sat_inc(count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_status_register.sv
// One-entry registered slot for ALU result/opcode/flags with pass-through ready,
// plus sticky flag accumulation and saturating operation/exception counters.
module alu_status_register
  import alu_pkg::*;
#(
  parameter int M  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  Q,
  input  logic [3:0]    ALUControl,
  input  logic          Z,
  input  logic          N,
  input  logic          V,
  input  logic          C,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_result,
  output logic [3:0]    out_op,
  output logic [3:0]    out_flags,
  input  logic          sticky_clr,
  output logic [3:0]    sticky_flags,
  output logic [CW-1:0] op_count,
  output logic [CW-1:0] exc_count
);

  slot_state_t state_q;
  slot_state_t state_d;

  logic [M-1:0] result_q;
  logic [3:0]   op_q;
  flags_t       flags_q;
  flags_t       sticky_q;
  flags_t       sticky_d;
  flags_t       flags_in;

  logic accept;
  logic drain;
  logic load;

  assign flags_in = pack_flags(N, Z, C, V);

  // Ready passes straight through from the consumer so a full slot can be
  // replaced in the same cycle it drains.
  assign in_ready = (state_q == ST_EMPTY) | out_ready;
  assign accept   = in_valid & in_ready;
  assign drain    = (state_q == ST_FULL) & out_ready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
          load    = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept) begin
          load = 1'b1;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      op_q     <= '0;
      flags_q  <= '0;
    end else if (load) begin
      result_q <= Q;
      op_q     <= ALUControl;
      flags_q  <= flags_in;
    end
  end

  // Clear is applied before the OR so flags captured alongside a clear survive.
  always_comb begin
    sticky_d = (sticky_clr ? flags_t'('0) : sticky_q) |
               (accept ? flags_in : flags_t'('0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  sat_counter #(.W(CW)) u_op_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept),
    .count (op_count)
  );

  sat_counter #(.W(CW)) u_exc_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (accept & (V | C)),
    .count (exc_count)
  );

  assign out_valid    = (state_q == ST_FULL);
  assign out_result   = result_q;
  assign out_op       = op_q;
  assign out_flags    = flags_q;
  assign sticky_flags = sticky_q;

endmodule
